// File: rtl/d_hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// d_hazard_unit_pkg
// Shared definitions for the decode-stage hazard/forwarding controller:
//   - 5-bit major opcode codes (instr[6:2]) for the RV32I base opcodes
//   - scoreboard entry field widths and the "register file" forwarding select
//   - packed structs for a scoreboard entry and for decoded register usage
// ---------------------------------------------------------------------------
package d_hazard_unit_pkg;

  localparam int RD_W       = 5;
  localparam int FWD_SEL_RF = 0;

  localparam logic [4:0] OPC_LOAD_5   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM_5 = 5'b00100;
  localparam logic [4:0] OPC_AUIPC_5  = 5'b00101;
  localparam logic [4:0] OPC_STORE_5  = 5'b01000;
  localparam logic [4:0] OPC_OP_5     = 5'b01100;
  localparam logic [4:0] OPC_LUI_5    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH_5 = 5'b11000;
  localparam logic [4:0] OPC_JALR_5   = 5'b11001;
  localparam logic [4:0] OPC_JAL_5    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM_5 = 5'b11100;

  // One in-flight destination tracked by the scoreboard.
  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            is_load;
  } sb_entry_t;

  // Register usage of the instruction sitting in decode.
  typedef struct packed {
    logic            uses_rs1;
    logic            uses_rs2;
    logic            writes_rd;
    logic            is_load;
    logic [RD_W-1:0] rs1;
    logic [RD_W-1:0] rs2;
    logic [RD_W-1:0] rd;
  } dec_t;

endpackage

// File: rtl/d_instr_regs.sv
// ---------------------------------------------------------------------------
// d_instr_regs
// Purely combinational register-usage decode of a 32-bit RV32 instruction.
// Ports:
//   i_instr  in  32  instruction in decode
//   o_dec    out     {uses_rs1, uses_rs2, writes_rd, is_load, rs1, rs2, rd}
// A write to x0 is never reported as writes_rd, so downstream logic never
// needs to special-case x0.
// ---------------------------------------------------------------------------
module d_instr_regs
  import d_hazard_unit_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  logic [4:0] w_opc;
  logic       w_unused;

  assign w_opc    = i_instr[6:2];
  // funct fields and the low opcode bits carry no register-usage information.
  assign w_unused = ^{i_instr[31:25], i_instr[14:12], i_instr[1:0]};

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_dec          = '0;
    o_dec.rs1      = i_instr[19:15];
    o_dec.rs2      = i_instr[24:20];
    o_dec.rd       = i_instr[11:7];
    o_dec.uses_rs1 = !(w_opc inside {OPC_LUI_5, OPC_AUIPC_5, OPC_JAL_5});
    o_dec.uses_rs2 = (w_opc inside {OPC_OP_5, OPC_BRANCH_5, OPC_STORE_5});
    o_dec.writes_rd = !(w_opc inside {OPC_BRANCH_5, OPC_STORE_5}) &&
                      (i_instr[11:7] != '0);
    o_dec.is_load  = (w_opc == OPC_LOAD_5);
  end

endmodule

// File: rtl/d_hazard_unit.sv
// ---------------------------------------------------------------------------
// d_hazard_unit
// Decode-stage hazard and forwarding controller. Tracks the destinations of
// the NUM_FWD_STAGES instructions ahead of decode in a registered scoreboard
// (entry k = instruction k stages past D, entry 1 = X) and produces operand
// forwarding selects, a load-use stall and a redirect flush.
//
// Parameters:
//   NUM_FWD_STAGES  stages after D that can forward a result
//   LOAD_LATENCY    stages a load occupies before it can forward (1..N-1)
//   SEL_W           width of each forwarding select
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   d_instr/d_valid instruction in decode and its valid flag
//   x_redirect      X is redirecting the PC this cycle
//   fwd_sel_rs1/2   0 = register file, k = result of stage k
//   stall           hold PC and IF/D, bubble into X
//   nop_sel         replace the decode instruction with a NOP
//   inflight        scoreboard valid bits (bit k-1 = stage k)
// Optional (macro HAZ_PERF_CNT_EN):
//   stall_cycles, flush_cycles  free-running 32-bit event counters
// ---------------------------------------------------------------------------
module d_hazard_unit
  import d_hazard_unit_pkg::*;
#(
  parameter int NUM_FWD_STAGES = 2,
  parameter int LOAD_LATENCY   = 1,
  parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               d_instr,
  input  logic                      d_valid,
  input  logic                      x_redirect,
  output logic [SEL_W-1:0]          fwd_sel_rs1,
  output logic [SEL_W-1:0]          fwd_sel_rs2,
  output logic                      stall,
  output logic                      nop_sel,
  output logic [NUM_FWD_STAGES-1:0] inflight
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               flush_cycles
`endif
);

  if (LOAD_LATENCY < 1 || LOAD_LATENCY >= NUM_FWD_STAGES) begin : g_bad_cfg
    $error("d_hazard_unit: LOAD_LATENCY must be in 1..NUM_FWD_STAGES-1");
  end

  dec_t                         w_dec;
  sb_entry_t [NUM_FWD_STAGES:1] r_sb;
  logic [SEL_W-1:0]             w_sel_rs1;
  logic [SEL_W-1:0]             w_sel_rs2;
  logic                         w_load_hit;
  logic                         w_redirect;
  logic                         w_stall;

  d_instr_regs u_decode (
    .i_instr (d_instr),
    .o_dec   (w_dec)
  );

  // Forwarding and load-use detection. Walking from the oldest stage to the
  // youngest lets the youngest match overwrite older ones. A load that has
  // not yet produced its data is skipped as a source and raises the stall.
  always_comb begin
    w_sel_rs1  = SEL_W'(FWD_SEL_RF);
    w_sel_rs2  = SEL_W'(FWD_SEL_RF);
    w_load_hit = 1'b0;
    for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
      if (r_sb[k].valid) begin
        if (r_sb[k].is_load && k <= LOAD_LATENCY) begin
          if ((w_dec.uses_rs1 && r_sb[k].rd == w_dec.rs1) ||
              (w_dec.uses_rs2 && r_sb[k].rd == w_dec.rs2)) begin
            w_load_hit = 1'b1;
          end
        end else begin
          if (w_dec.uses_rs1 && r_sb[k].rd == w_dec.rs1) w_sel_rs1 = SEL_W'(k);
          if (w_dec.uses_rs2 && r_sb[k].rd == w_dec.rs2) w_sel_rs2 = SEL_W'(k);
        end
      end
    end
  end

  // A redirect kills the decode instruction outright, so it wins over stall.
  assign w_redirect = x_redirect & ~rst;
  assign w_stall    = d_valid & w_load_hit & ~w_redirect;

  // NOTE: the scoreboard valid bits decide forwarding, so every entry is
  // cleared on reset rather than left to settle from stale contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage shifts from the
      // pre-edge values, independent of statement order.
      for (int k = NUM_FWD_STAGES; k >= 2; k--) begin
        r_sb[k] <= r_sb[k-1];
      end
      r_sb[1].valid   <= d_valid & w_dec.writes_rd & ~w_stall & ~w_redirect;
      r_sb[1].rd      <= w_dec.rd;
      r_sb[1].is_load <= w_dec.is_load;
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 1; k <= NUM_FWD_STAGES; k++) begin
      inflight[k-1] = r_sb[k].valid;
    end
  end

  assign fwd_sel_rs1 = w_sel_rs1;
  assign fwd_sel_rs2 = w_sel_rs2;
  assign stall       = w_stall;
  assign nop_sel     = w_redirect;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else begin
      if (w_stall)    r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_redirect) r_flush_cycles <= r_flush_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_cycles = r_flush_cycles;
`endif

endmodule

// File: tb/tb_d_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_d_hazard_unit
// Scoreboard bench for d_hazard_unit (NUM_FWD_STAGES = 2, LOAD_LATENCY = 1).
// The driver applies one decode-cycle of stimulus at a time, computes the
// expected outputs from a history-of-issued-instructions reference model and
// queues them; a monitor pops and compares on each falling edge. Directed
// scenarios queue hand-derived expectations; the random phase uses the model.
// Define HAZ_PERF_CNT_EN to also check the event counters.
// ---------------------------------------------------------------------------
module tb_d_hazard_unit;

  localparam int N  = 2;
  localparam int LL = 1;
  localparam int SW = $clog2(N + 1);

  localparam logic [4:0] T_LOAD = 5'b00000, T_OPIMM = 5'b00100, T_AUIPC = 5'b00101,
                         T_STORE = 5'b01000, T_OP = 5'b01100, T_LUI = 5'b01101,
                         T_BRANCH = 5'b11000, T_JALR = 5'b11001, T_JAL = 5'b11011,
                         T_SYSTEM = 5'b11100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    bit              chk;
    logic [SW-1:0]   s1;
    logic [SW-1:0]   s2;
    logic            st;
    logic            nop;
    logic [N-1:0]    inf;
    logic [31:0]     sc;
    logic [31:0]     fc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       d_instr;
  logic              d_valid;
  logic              x_redirect;
  logic [SW-1:0]     fwd_sel_rs1;
  logic [SW-1:0]     fwd_sel_rs2;
  logic              stall;
  logic              nop_sel;
  logic [N-1:0]      inflight;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       flush_cycles;
`endif

  always #5 clk = ~clk;

  d_hazard_unit #(.NUM_FWD_STAGES(N), .LOAD_LATENCY(LL)) dut (
    .clk         (clk),
    .rst         (rst),
    .d_instr     (d_instr),
    .d_valid     (d_valid),
    .x_redirect  (x_redirect),
    .fwd_sel_rs1 (fwd_sel_rs1),
    .fwd_sel_rs2 (fwd_sel_rs2),
    .stall       (stall),
    .nop_sel     (nop_sel),
    .inflight    (inflight)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_cycles(flush_cycles)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model: what the last N issued decode slots left behind.
  bit          m_v  [1:N];
  logic [4:0]  m_rd [1:N];
  bit          m_ld [1:N];
  int unsigned m_sc = 0;
  int unsigned m_fc = 0;
  bit          last_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] opc, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, opc, 2'b11};
  endfunction

  function automatic exp_t mk(input int s1, input int s2, input bit st, input bit nop,
                              input int inf);
    exp_t e;
    e.chk = 1'b1;
    e.s1  = SW'(s1);
    e.s2  = SW'(s2);
    e.st  = st;
    e.nop = nop;
    e.inf = N'(inf);
    e.sc  = '0;
    e.fc  = '0;
    return e;
  endfunction

  // One decode cycle: set inputs, queue the expectation, advance the model,
  // then wait for the clock edge that consumes the stimulus.
  task automatic drive(input logic [31:0] instr, input bit v, input bit redir, input bit r,
                       input bit chk, input bit hand, input exp_t hexp);
    exp_t       e;
    logic [4:0] opc, rs1, rs2, rd;
    bit         u1, u2, wr, ld, hit, redir_eff;
    opc = instr[6:2];
    rd  = instr[11:7];
    rs1 = instr[19:15];
    rs2 = instr[24:20];
    u1  = !(opc == T_LUI || opc == T_AUIPC || opc == T_JAL);
    u2  = (opc == T_OP || opc == T_BRANCH || opc == T_STORE);
    wr  = !(opc == T_BRANCH || opc == T_STORE) && rd != 0;
    ld  = (opc == T_LOAD);

    e     = mk(0, 0, 0, 0, 0);
    e.chk = chk;
    hit   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (m_v[k]) begin
        e.inf[k-1] = 1'b1;
        if (m_ld[k] && k <= LL) begin
          if ((u1 && m_rd[k] == rs1) || (u2 && m_rd[k] == rs2)) hit = 1'b1;
        end else begin
          if (e.s1 == 0 && u1 && m_rd[k] == rs1) e.s1 = SW'(k);
          if (e.s2 == 0 && u2 && m_rd[k] == rs2) e.s2 = SW'(k);
        end
      end
    end
    redir_eff = redir && !r;
    e.nop = redir_eff;
    e.st  = v && hit && !redir_eff;
    e.sc  = m_sc;
    e.fc  = m_fc;
    if (hand) begin
      e.s1 = hexp.s1; e.s2 = hexp.s2; e.st = hexp.st; e.nop = hexp.nop; e.inf = hexp.inf;
    end

    d_instr    = instr;
    d_valid    = v;
    x_redirect = redir;
    rst        = r;
    exp_q.push_back(e);
    last_stall = e.st;

    if (r) begin
      for (int k = 1; k <= N; k++) m_v[k] = 1'b0;
      m_sc = 0;
      m_fc = 0;
    end else begin
      for (int k = N; k >= 2; k--) begin
        m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1];
      end
      m_v[1]  = v && wr && !e.st && !redir_eff;
      m_rd[1] = rd;
      m_ld[1] = ld;
      if (e.st)      m_sc++;
      if (redir_eff) m_fc++;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [31:0] instr, input bit redir = 0, input bit r = 0);
    drive(instr, 1'b1, redir, r, 1'b1, 1'b0, mk(0, 0, 0, 0, 0));
  endtask

  task automatic step_hand(input logic [31:0] instr, input bit redir, input bit r,
                           input exp_t h);
    drive(instr, 1'b1, redir, r, 1'b1, 1'b1, h);
  endtask

  task automatic flush();
    step(NOP);
    step(NOP);
  endtask

  // Monitor: compares whatever the driver queued for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk) begin
        check("fwd_sel_rs1", 32'(fwd_sel_rs1), 32'(e.s1));
        check("fwd_sel_rs2", 32'(fwd_sel_rs2), 32'(e.s2));
        check("stall",       32'(stall),       32'(e.st));
        check("nop_sel",     32'(nop_sel),     32'(e.nop));
        check("inflight",    32'(inflight),    32'(e.inf));
`ifdef HAZ_PERF_CNT_EN
        check("stall_cycles", stall_cycles, e.sc);
        check("flush_cycles", flush_cycles, e.fc);
`endif
      end
    end
  end

  initial begin
    logic [4:0]  opcs [10];
    logic [31:0] instr;
    int          wait_cnt;
    opcs = '{T_LOAD, T_OPIMM, T_AUIPC, T_STORE, T_OP, T_LUI, T_BRANCH, T_JALR, T_JAL, T_SYSTEM};
    for (int k = 1; k <= N; k++) begin
      m_v[k] = 1'b0; m_rd[k] = '0; m_ld[k] = 1'b0;
    end
    rst = 1'b1; d_instr = NOP; d_valid = 1'b0; x_redirect = 1'b0;
    @(posedge clk);
    #1;

    // Reset: first cycle state is unknown, afterwards all outputs are 0,
    // and a redirect during reset is masked.
    drive(NOP, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0));
    step_hand(NOP, 1'b1, 1'b1, mk(0, 0, 0, 0, 0));
    step(NOP);

    // Forward from X.
    flush();
    step(enc(T_OPIMM, 5, 0, 1));
    step_hand(enc(T_OP, 6, 5, 5), 1'b0, 1'b0, mk(1, 1, 0, 0, 2'b01));

    // Forward from stage 2.
    flush();
    step(enc(T_OPIMM, 5, 0, 1));
    step(NOP);
    step_hand(enc(T_OP, 7, 5, 1), 1'b0, 1'b0, mk(2, 0, 0, 0, 2'b10));

    // Youngest stage wins.
    flush();
    step(enc(T_OPIMM, 3, 0, 1));
    step(enc(T_OPIMM, 3, 0, 2));
    step_hand(enc(T_OP, 4, 3, 0), 1'b0, 1'b0, mk(1, 0, 0, 0, 2'b11));

    // Load-use: one stall cycle, then forward from stage 2 with a bubble.
    flush();
    step(enc(T_LOAD, 8, 1, 0));
    step_hand(enc(T_OP, 9, 8, 0), 1'b0, 1'b0, mk(0, 0, 1, 0, 2'b01));
    step_hand(enc(T_OP, 9, 8, 0), 1'b0, 1'b0, mk(2, 0, 0, 0, 2'b10));

    // Redirect overrides load-use stall; the killed instruction is not entered.
    flush();
    step(enc(T_LOAD, 8, 1, 0));
    step_hand(enc(T_OP, 9, 8, 0), 1'b1, 1'b0, mk(0, 0, 0, 1, 2'b01));
    step_hand(NOP, 1'b0, 1'b0, mk(0, 0, 0, 0, 2'b10));

    // Back-to-back redirects each flush.
    flush();
    step_hand(enc(T_OPIMM, 5, 0, 1), 1'b1, 1'b0, mk(0, 0, 0, 1, 2'b00));
    step_hand(enc(T_OPIMM, 6, 0, 1), 1'b1, 1'b0, mk(0, 0, 0, 1, 2'b00));
    step_hand(NOP, 1'b0, 1'b0, mk(0, 0, 0, 0, 2'b00));

    // x0 never forwards.
    flush();
    step(enc(T_OPIMM, 0, 0, 5));
    step_hand(enc(T_OP, 1, 0, 0), 1'b0, 1'b0, mk(0, 0, 0, 0, 2'b00));

    // Reset in the middle of a load-use stall.
    flush();
    step(enc(T_LOAD, 8, 1, 0));
    drive(enc(T_OP, 9, 8, 0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0));
    step_hand(enc(T_OP, 9, 8, 0), 1'b0, 1'b0, mk(0, 0, 0, 0, 2'b00));

    // Random traffic against the reference model.
    instr = NOP;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        instr = enc(opcs[$urandom_range(0, 9)], 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        instr[31:25] = 7'($urandom);
        instr[14:12] = 3'($urandom);
      end
      drive(instr, ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 63) == 0), 1'b1, 1'b0, mk(0, 0, 0, 0, 0));
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
